white_ballance_stat: RTL and testbench



---
 rtl/white_ballance_stat.sv | 196 +++++++++++++++++++
 tb/tb_white_ballance_stat.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/white_ballance_stat.sv
// white_ballance_stat
//   Per-frame R/G/B sum collector sitting in front of the white-balance
//   corrector. The RGB AXI4-Stream is forwarded through one register stage
//   unchanged; sums of every complete, well-formed frame are offered on a
//   valid/ready result port. Malformed frames are dropped and flagged.
//
//   Build option: define WB_STAT_CLIP_EN to exclude clipped pixels (any
//   component at full scale) from the sums and the pixel count. Such pixels
//   are still forwarded and still count toward line/frame geometry.
module white_ballance_stat #(
  parameter int PX_WIDTH    = 30,
  parameter int TDATA_WIDTH = 32,
  parameter int FRAME_RES_X = 1920,
  parameter int FRAME_RES_Y = 1080,
  parameter int SUM_WIDTH   = PX_WIDTH / 3 + $clog2(FRAME_RES_X * FRAME_RES_Y)
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  // input stream
  input  logic                   video_i_tvalid,
  output logic                   video_i_tready,
  input  logic [TDATA_WIDTH-1:0] video_i_tdata,
  input  logic                   video_i_tlast,
  input  logic                   video_i_tuser,
  // output stream
  output logic                   video_o_tvalid,
  input  logic                   video_o_tready,
  output logic [TDATA_WIDTH-1:0] video_o_tdata,
  output logic                   video_o_tlast,
  output logic                   video_o_tuser,
  // frame statistics
  output logic                   stat_valid_o,
  input  logic                   stat_ready_i,
  output logic [SUM_WIDTH-1:0]   stat_r_o,
  output logic [SUM_WIDTH-1:0]   stat_g_o,
  output logic [SUM_WIDTH-1:0]   stat_b_o,
  output logic [SUM_WIDTH-1:0]   stat_px_cnt_o,
  output logic                   stat_overrun_o,
  output logic                   frame_err_o
);

  localparam int COMP_WIDTH = PX_WIDTH / 3;
  localparam int X_W        = (FRAME_RES_X > 1) ? $clog2(FRAME_RES_X) : 1;
  localparam int Y_W        = (FRAME_RES_Y > 1) ? $clog2(FRAME_RES_Y) : 1;

  typedef enum logic {
    IDLE,
    ACCUM
  } state_t;

  state_t               state;
  logic [X_W-1:0]       x_cnt;
  logic [Y_W-1:0]       y_cnt;
  logic [SUM_WIDTH-1:0] sum_r, sum_g, sum_b, sum_cnt;

  logic                  accept;
  logic [COMP_WIDTH-1:0] pix_r, pix_g, pix_b;
  logic                  pix_used;
  logic [SUM_WIDTH-1:0]  add_r, add_g, add_b, add_cnt;
  logic                  line_end, last_line;

  assign video_i_tready = !video_o_tvalid || video_o_tready;
  assign accept         = video_i_tvalid && video_i_tready;

  assign pix_r = video_i_tdata[COMP_WIDTH-1:0];
  assign pix_g = video_i_tdata[2*COMP_WIDTH-1:COMP_WIDTH];
  assign pix_b = video_i_tdata[3*COMP_WIDTH-1:2*COMP_WIDTH];

`ifdef WB_STAT_CLIP_EN
  assign pix_used = !((&pix_r) || (&pix_g) || (&pix_b));
`else
  assign pix_used = 1'b1;
`endif

  assign line_end  = (x_cnt == X_W'(FRAME_RES_X - 1));
  assign last_line = (y_cnt == Y_W'(FRAME_RES_Y - 1));

  // Contribution of the current beat, zero when the pixel is excluded.
  always_comb begin
    add_r   = '0;
    add_g   = '0;
    add_b   = '0;
    add_cnt = {{(SUM_WIDTH-1){1'b0}}, pix_used};
    if (pix_used) begin
      add_r = {{(SUM_WIDTH-COMP_WIDTH){1'b0}}, pix_r};
      add_g = {{(SUM_WIDTH-COMP_WIDTH){1'b0}}, pix_g};
      add_b = {{(SUM_WIDTH-COMP_WIDTH){1'b0}}, pix_b};
    end
  end

  // One-stage skid-free pipeline register for the pass-through stream.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      video_o_tvalid <= 1'b0;
      video_o_tdata  <= '0;
      video_o_tlast  <= 1'b0;
      video_o_tuser  <= 1'b0;
    end else if (accept) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values, matching real flip-flops.
      video_o_tvalid <= 1'b1;
      video_o_tdata  <= video_i_tdata;
      video_o_tlast  <= video_i_tlast;
      video_o_tuser  <= video_i_tuser;
    end else if (video_o_tready) begin
      video_o_tvalid <= 1'b0;
    end
  end

  // Frame FSM: geometry tracking, accumulation and result hand-off.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state          <= IDLE;
      x_cnt          <= '0;
      y_cnt          <= '0;
      sum_r          <= '0;
      sum_g          <= '0;
      sum_b          <= '0;
      sum_cnt        <= '0;
      stat_valid_o   <= 1'b0;
      stat_r_o       <= '0;
      stat_g_o       <= '0;
      stat_b_o       <= '0;
      stat_px_cnt_o  <= '0;
      stat_overrun_o <= 1'b0;
      frame_err_o    <= 1'b0;
    end else begin
      stat_overrun_o <= 1'b0;
      frame_err_o    <= 1'b0;

      // NOTE: a consumed result is cleared here; a frame completing in the
      // same cycle assigns the result registers again further down, and the
      // last non-blocking assignment in the block is the one that sticks.
      if (stat_valid_o && stat_ready_i) begin
        stat_valid_o  <= 1'b0;
        stat_r_o      <= '0;
        stat_g_o      <= '0;
        stat_b_o      <= '0;
        stat_px_cnt_o <= '0;
      end

      if (accept) begin
        unique case (state)
          IDLE: begin
            if (video_i_tuser) begin
              sum_r   <= add_r;
              sum_g   <= add_g;
              sum_b   <= add_b;
              sum_cnt <= add_cnt;
              x_cnt   <= X_W'(1);
              y_cnt   <= '0;
              state   <= ACCUM;
            end
          end
          ACCUM: begin
            if (video_i_tuser) begin
              // Unexpected SOF: drop the partial frame and restart on this beat.
              frame_err_o <= 1'b1;
              sum_r       <= add_r;
              sum_g       <= add_g;
              sum_b       <= add_b;
              sum_cnt     <= add_cnt;
              x_cnt       <= X_W'(1);
              y_cnt       <= '0;
            end else if (video_i_tlast != line_end) begin
              // Line too short or too long.
              frame_err_o <= 1'b1;
              state       <= IDLE;
            end else if (video_i_tlast && last_line) begin
              stat_r_o       <= sum_r + add_r;
              stat_g_o       <= sum_g + add_g;
              stat_b_o       <= sum_b + add_b;
              stat_px_cnt_o  <= sum_cnt + add_cnt;
              stat_valid_o   <= 1'b1;
              stat_overrun_o <= stat_valid_o && !stat_ready_i;
              state          <= IDLE;
            end else begin
              sum_r   <= sum_r + add_r;
              sum_g   <= sum_g + add_g;
              sum_b   <= sum_b + add_b;
              sum_cnt <= sum_cnt + add_cnt;
              if (video_i_tlast) begin
                x_cnt <= '0;
                y_cnt <= y_cnt + Y_W'(1);
              end else begin
                x_cnt <= x_cnt + X_W'(1);
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_white_ballance_stat.sv
// Directed testbench for white_ballance_stat on a 4x2 frame.
module tb_white_ballance_stat;

  localparam int PXW = 30;
  localparam int TDW = 32;
  localparam int RX  = 4;
  localparam int RY  = 2;
  localparam int SW  = 13;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           video_i_tvalid, video_i_tready, video_i_tlast, video_i_tuser;
  logic [TDW-1:0] video_i_tdata;
  logic           video_o_tvalid, video_o_tready, video_o_tlast, video_o_tuser;
  logic [TDW-1:0] video_o_tdata;
  logic           stat_valid, stat_ready, stat_overrun, frame_err;
  logic [SW-1:0]  stat_r, stat_g, stat_b, stat_px_cnt;

  int checks   = 0;
  int failures = 0;
  int err_cnt  = 0;
  int ovr_cnt  = 0;
  logic [TDW+1:0] out_q[$];
  logic [TDW+1:0] exp_q[$];

  always #5 clk = ~clk;

  white_ballance_stat #(
    .PX_WIDTH(PXW), .TDATA_WIDTH(TDW), .FRAME_RES_X(RX), .FRAME_RES_Y(RY)
  ) dut (
    .clk_i          (clk),
    .rst_n_i        (rst_n),
    .video_i_tvalid (video_i_tvalid),
    .video_i_tready (video_i_tready),
    .video_i_tdata  (video_i_tdata),
    .video_i_tlast  (video_i_tlast),
    .video_i_tuser  (video_i_tuser),
    .video_o_tvalid (video_o_tvalid),
    .video_o_tready (video_o_tready),
    .video_o_tdata  (video_o_tdata),
    .video_o_tlast  (video_o_tlast),
    .video_o_tuser  (video_o_tuser),
    .stat_valid_o   (stat_valid),
    .stat_ready_i   (stat_ready),
    .stat_r_o       (stat_r),
    .stat_g_o       (stat_g),
    .stat_b_o       (stat_b),
    .stat_px_cnt_o  (stat_px_cnt),
    .stat_overrun_o (stat_overrun),
    .frame_err_o    (frame_err)
  );

  // Output beat capture and pulse counters.
  always @(posedge clk) begin
    if (rst_n) begin
      if (video_o_tvalid && video_o_tready)
        out_q.push_back({video_o_tuser, video_o_tlast, video_o_tdata});
      if (frame_err)    err_cnt++;
      if (stat_overrun) ovr_cnt++;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send_beat(input logic [TDW-1:0] d, input logic last, input logic user,
                           input bit rnd, input bit chk_lat);
    bit done = 1'b0;
    exp_q.push_back({user, last, d});
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      video_i_tvalid = 1'b1;
      video_i_tdata  = d;
      video_i_tlast  = last;
      video_i_tuser  = user;
      if (rnd) video_o_tready = 1'($urandom_range(0, 1));
      #1;
      if (video_i_tready) begin
        @(posedge clk);
        done = 1'b1;
      end
    end
    if (!done) check("accept_timeout", 64'(0), 64'(1));
    if (chk_lat && done) begin
      #1;
      check("latency_tvalid", 64'(video_o_tvalid), 64'(1));
      check("latency_beat", 64'({video_o_tuser, video_o_tlast, video_o_tdata}),
            64'({user, last, d}));
    end
  endtask

  function automatic logic [TDW-1:0] pix(input int idx, input int r, input int g, input int b);
    logic [1:0] up;
    up = idx[1:0];
    return {up, 10'(b), 10'(g), 10'(r)};
  endfunction

  task automatic go_idle();
    @(negedge clk);
    video_i_tvalid = 1'b0;
  endtask

  task automatic send_frame(input int r, input int g, input int b, input bit rnd,
                            input bit chk_lat, input bit clip);
    for (int y = 0; y < RY; y++)
      for (int x = 0; x < RX; x++) begin
        int idx;
        int gv;
        idx = y * RX + x;
        gv  = (clip && (idx == 1 || idx == 5)) ? 1023 : g;
        send_beat(pix(idx, r, gv, b), x == RX - 1, idx == 0, rnd, chk_lat);
      end
    go_idle();
  endtask

  task automatic check_result(input string tag, input int r, input int g, input int b, input int n);
    check({tag, "_valid"}, 64'(stat_valid), 64'(1));
    check({tag, "_r"}, 64'(stat_r), 64'(r));
    check({tag, "_g"}, 64'(stat_g), 64'(g));
    check({tag, "_b"}, 64'(stat_b), 64'(b));
    check({tag, "_cnt"}, 64'(stat_px_cnt), 64'(n));
  endtask

  task automatic consume(input string tag);
    @(negedge clk);
    stat_ready = 1'b1;
    @(posedge clk);
    #1;
    check({tag, "_valid_drop"}, 64'(stat_valid), 64'(0));
    check({tag, "_cleared"}, 64'({stat_r, stat_g, stat_b, stat_px_cnt}), 64'(0));
    @(negedge clk);
    stat_ready = 1'b0;
  endtask

  task automatic drain_compare(input string tag);
    int n;
    @(negedge clk);
    video_o_tready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check({tag, "_beat_count"}, 64'(out_q.size()), 64'(exp_q.size()));
    n = (out_q.size() < exp_q.size()) ? out_q.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      check({tag, "_beat"}, 64'(out_q[i]), 64'(exp_q[i]));
    out_q.delete();
    exp_q.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_stream"}, 64'({video_o_tvalid, video_o_tlast, video_o_tuser, video_o_tdata}), 64'(0));
    check({tag, "_stat"}, 64'({stat_valid, stat_overrun, frame_err, stat_r, stat_g, stat_b}), 64'(0));
    check({tag, "_cnt"}, 64'(stat_px_cnt), 64'(0));
  endtask

  initial begin
    int e0;
    int o0;
    rst_n          = 1'b0;
    video_i_tvalid = 1'b0;
    video_i_tdata  = '0;
    video_i_tlast  = 1'b0;
    video_i_tuser  = 1'b0;
    video_o_tready = 1'b1;
    stat_ready     = 1'b0;

    // Reset values.
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Clean frame, no backpressure, per-beat latency check.
    check("pre_frame_valid", 64'(stat_valid), 64'(0));
    send_frame(1, 2, 3, 1'b0, 1'b1, 1'b0);
    check_result("frame1", 8, 16, 24, 8);
    drain_compare("frame1_stream");
    consume("frame1");

    // Random output backpressure.
    send_frame(1, 2, 3, 1'b1, 1'b0, 1'b0);
    check_result("stall", 8, 16, 24, 8);
    drain_compare("stall_stream");
    consume("stall");

    // Early tlast on beat index 2 of line 0.
    e0 = err_cnt;
    send_beat(pix(0, 1, 2, 3), 1'b0, 1'b1, 1'b0, 1'b0);
    send_beat(pix(1, 1, 2, 3), 1'b0, 1'b0, 1'b0, 1'b0);
    send_beat(pix(2, 1, 2, 3), 1'b1, 1'b0, 1'b0, 1'b0);
    go_idle();
    repeat (2) @(posedge clk);
    #1;
    check("short_line_err", 64'(err_cnt - e0), 64'(1));
    check("short_line_no_result", 64'(stat_valid), 64'(0));
    send_frame(1, 2, 3, 1'b0, 1'b0, 1'b0);
    check_result("after_err", 8, 16, 24, 8);
    drain_compare("err_stream");
    consume("after_err");

    // SOF in the middle of a frame restarts accumulation.
    e0 = err_cnt;
    send_beat(pix(0, 5, 6, 7), 1'b0, 1'b1, 1'b0, 1'b0);
    send_beat(pix(1, 5, 6, 7), 1'b0, 1'b0, 1'b0, 1'b0);
    send_frame(1, 2, 3, 1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check("resof_err", 64'(err_cnt - e0), 64'(1));
    check_result("resof", 8, 16, 24, 8);
    drain_compare("resof_stream");
    consume("resof");

    // Two frames without consumption: one overrun, frame 2 kept.
    o0 = ovr_cnt;
    send_frame(1, 2, 3, 1'b0, 1'b0, 1'b0);
    send_frame(2, 4, 6, 1'b0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("overrun_pulses", 64'(ovr_cnt - o0), 64'(1));
    check_result("overrun_hold", 16, 32, 48, 8);
    drain_compare("overrun_stream");
    consume("overrun");

    // Two pixels with G at full scale.
    send_frame(1, 2, 3, 1'b0, 1'b0, 1'b1);
`ifdef WB_STAT_CLIP_EN
    check_result("clip", 6, 12, 18, 6);
`else
    check_result("clip", 8, 2058, 24, 8);
`endif
    drain_compare("clip_stream");
    consume("clip");

    // Reset after 5 pixels, then a full frame.
    for (int i = 0; i < 5; i++)
      send_beat(pix(i, 1, 2, 3), i == RX - 1, i == 0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n          = 1'b0;
    video_i_tvalid = 1'b0;
    #1;
    check_reset_outputs("midreset");
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("midreset_hold");
    @(negedge clk);
    rst_n = 1'b1;
    out_q.delete();
    exp_q.delete();
    send_frame(3, 3, 3, 1'b0, 1'b0, 1'b0);
    check_result("post_reset", 24, 24, 24, 8);
    drain_compare("post_reset_stream");
    consume("post_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
